mfm_sync_search_ctrl: RTL
=========================

// Module: mfm_sync_search_ctrl
// PURPOSE
//  Sequences one MFM sync-word search-and-acquire operation. It watches the sync word
//  detector output (SYNC_WORD_DETECTED) and the index pulse, and can arm on an index pulse.
//  It needs MATCH_COUNT consecutive sync matches, each within GAP_LIMIT clocks of the last.
//  It then asserts ACQ_RUN for ACQ_LEN clocks to gate the acquisition engine.
//  It times out after INDEX_LIMIT index pulses with no complete sync sequence.
// PARAMETERS
//  GAP_W  12  width of GAP_LIMIT and of the inter-match gap counter
//  LEN_W  20  width of ACQ_LEN and of the acquisition counter
//  CNT_W  4   width of MATCH_COUNT and of the match counter
// PORTS
//  CLK_PLL32MHZ  in   1      master clock, 32 MHz
//  RESET_n       in   1      asynchronous, active-low reset
//  START         in   1      1-clk pulse; accepted only in IDLE/DONE/TIMEOUT
//  ABORT         in   1      level; forces return to IDLE, highest priority after reset
//  WAIT_INDEX    in   1      1 = search starts at the next index edge; sampled at START
//  MATCH_COUNT   in   CNT_W  consecutive matches required; 0 treated as 1; sampled at START
//  GAP_LIMIT     in   GAP_W  max clocks between matches; sampled at START
//  INDEX_LIMIT   in   8      index edges before timeout; 0 = never; sampled at START
//  ACQ_LEN       in   LEN_W  clocks of ACQ_RUN; 0 = run until ABORT; sampled at START
//  SYNC_DET_IN   in   1      from the sync detector (DATASEP clock domain, async here)
//  INDEX_IN      in   1      drive index pulse, async, active-high
//  ACQ_RUN       out  1      acquisition gate
//  SYNC_FOUND    out  1      1-clk pulse when the sync sequence completes
//  BUSY          out  1      high in WAIT_IDX / SEARCH / ACQUIRE
//  DONE          out  1      sticky; cleared by START or ABORT
//  TIMED_OUT     out  1      sticky; cleared by START or ABORT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0.
//  Input conditioning:
//   - SYNC_DET_IN and INDEX_IN each pass a 2-FF synchroniser plus a rising-edge detector.
//   - match_e / index_e are 1-clk pulses, 3 clocks after the input edge.
//   - A held-high detector output counts as one match.
//  States:
//   - IDLE:
//     - START latches the config and clears DONE/TIMED_OUT.
//     - Goes to WAIT_IDX if WAIT_INDEX = 1, else to SEARCH.
//   - WAIT_IDX: on index_e -> SEARCH, with the index counter reset to 0.
//   - SEARCH:
//     - match_e: mcnt++ and the gap counter clears.
//     - If mcnt+1 >= MATCH_COUNT: pulse SYNC_FOUND -> ACQUIRE; ACQ_RUN is high the next clock.
//     - With mcnt > 0 and no match_e, the gap counter increments.
//     - When the gap counter reaches GAP_LIMIT, mcnt returns to 0 (sequence broken).
//     - index_e in SEARCH increments the index counter.
//     - When the index counter reaches INDEX_LIMIT (nonzero), the block enters TIMEOUT and sets TIMED_OUT.
//     - Same-clock match_e and index_e: match_e wins; completion beats timeout.
//   - ACQUIRE:
//     - ACQ_RUN = 1; the length counter counts 1..ACQ_LEN.
//     - At ACQ_LEN it goes to DONE and sets DONE; ACQ_RUN falls the same edge.
//     - ACQ_RUN is high for exactly ACQ_LEN clocks.
//     - Index pulses and matches are ignored.
//   - DONE / TIMEOUT: idle equivalents that keep their sticky flag; START restarts the operation.
//  START while BUSY is ignored.
//  ABORT (any state):
//   - next state is IDLE; ACQ_RUN, DONE and TIMED_OUT go to 0 and counters clear.
//   - ABORT with START on the same clock: ABORT wins.
//  Counters saturate and never wrap.
//  Comparisons are unsigned and the full width of each counter.
// STRUCTURE
//  Shared package: state encodings (IDLE, WAIT_IDX, SEARCH, ACQUIRE, DONE, TIMEOUT).
//   Also the default widths GAP_W, LEN_W and CNT_W.
//  Sub-module: sync_edge_detect, a 2-FF synchroniser plus rising-edge pulse.
//   It is instantiated twice, for SYNC_DET_IN and INDEX_IN.
// TESTING
//  - WAIT_INDEX=0, MATCH_COUNT=3, GAP_LIMIT=600, ACQ_LEN=100; 3 matches 512 clk apart:
//    SYNC_FOUND once, ACQ_RUN high exactly 100 clk, then DONE=1 and BUSY=0.
//  - MATCH_COUNT=3, GAP_LIMIT=600; matches at t=0, 512, 1300, 1812, 2324:
//    the sequence resets after the 2nd match and SYNC_FOUND fires on the 5th match only.
//  - INDEX_LIMIT=2, no matches, index pulses every 10000 clk: TIMED_OUT=1 at the 2nd index edge.
//    ACQ_RUN never rises.
//  - WAIT_INDEX=1, matches before the first index are ignored.
//    After the index edge, MATCH_COUNT=1 and one match start ACQUIRE.
//  - ABORT asserted 50 clk into ACQUIRE (ACQ_LEN=0): ACQ_RUN=0 on the next clock, state IDLE.
//    START issued mid-ACQUIRE is ignored.
//  - RESET_n low mid-SEARCH: all outputs 0 immediately (async), state IDLE.

Source files
------------

// File: rtl/mfm_sync_search_ctrl_pkg.sv
// Shared definitions for the MFM sync-word search controller:
// FSM state encoding and default counter widths.
package mfm_sync_search_ctrl_pkg;

    localparam int DEF_GAP_W = 12;  // inter-match gap counter / GAP_LIMIT
    localparam int DEF_LEN_W = 20;  // acquisition length counter / ACQ_LEN
    localparam int DEF_CNT_W = 4;   // match counter / MATCH_COUNT

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_IDX = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_ACQUIRE  = 3'd3,
        ST_DONE     = 3'd4,
        ST_TIMEOUT  = 3'd5
    } state_t;

endpackage

// File: rtl/mfm_sync_search_ctrl_if.sv
// Control/status bundle of the sync search controller.
//   slave  : the controller (takes command/config + raw detector/index inputs,
//            drives ACQ_RUN, SYNC_FOUND, BUSY, DONE, TIMED_OUT)
//   master : the host side driving commands and observing status
interface mfm_sync_search_ctrl_if
    import mfm_sync_search_ctrl_pkg::*;
#(
    parameter int GAP_W = DEF_GAP_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) ();
    logic             START;
    logic             ABORT;
    logic             WAIT_INDEX;
    logic [CNT_W-1:0] MATCH_COUNT;
    logic [GAP_W-1:0] GAP_LIMIT;
    logic [7:0]       INDEX_LIMIT;
    logic [LEN_W-1:0] ACQ_LEN;
    logic             SYNC_DET_IN;
    logic             INDEX_IN;
    logic             ACQ_RUN;
    logic             SYNC_FOUND;
    logic             BUSY;
    logic             DONE;
    logic             TIMED_OUT;

    modport slave (
        input  START, ABORT, WAIT_INDEX, MATCH_COUNT, GAP_LIMIT, INDEX_LIMIT,
               ACQ_LEN, SYNC_DET_IN, INDEX_IN,
        output ACQ_RUN, SYNC_FOUND, BUSY, DONE, TIMED_OUT
    );

    modport master (
        output START, ABORT, WAIT_INDEX, MATCH_COUNT, GAP_LIMIT, INDEX_LIMIT,
               ACQ_LEN, SYNC_DET_IN, INDEX_IN,
        input  ACQ_RUN, SYNC_FOUND, BUSY, DONE, TIMED_OUT
    );
endinterface

// File: rtl/mfm_sync_search_ctrl_sync_edge_detect.sv
// sync_edge_detect: 2-FF synchroniser followed by a registered rising-edge
// detector. pulse is high for one clock, 3 clocks after din rises; a held-high
// din produces a single pulse.
//   clk, rst_n : clock, async active-low reset
//   din        : asynchronous input
//   pulse      : 1-clk rising-edge pulse
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);
    // pipe[0], pipe[1]: synchroniser; pipe[2]: previous synchronised value
    logic [2:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe  <= '0;
            pulse <= 1'b0;
        end else begin
            pipe  <= {pipe[1:0], din};
            pulse <= pipe[1] & ~pipe[2];
        end
    end
endmodule

// File: rtl/mfm_sync_search_ctrl.sv
// mfm_sync_search_ctrl: runs one MFM sync-word search and acquisition.
// Optionally arms on an index edge, then requires MATCH_COUNT consecutive
// detector matches, each within GAP_LIMIT clocks of the previous one, then
// gates the acquisition engine with ACQ_RUN for ACQ_LEN clocks (0 = until
// ABORT). Gives up after INDEX_LIMIT index edges (0 = never).
//   CLK_PLL32MHZ : 32 MHz master clock
//   RESET_n      : async active-low reset
//   bus          : command/config inputs, raw detector/index, status outputs
module mfm_sync_search_ctrl
    import mfm_sync_search_ctrl_pkg::*;
#(
    parameter int GAP_W = DEF_GAP_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   CLK_PLL32MHZ,
    input  logic                   RESET_n,
    mfm_sync_search_ctrl_if.slave  bus
);
    logic match_e, index_e;

    sync_edge_detect u_sync_det (
        .clk   (CLK_PLL32MHZ),
        .rst_n (RESET_n),
        .din   (bus.SYNC_DET_IN),
        .pulse (match_e)
    );

    sync_edge_detect u_index (
        .clk   (CLK_PLL32MHZ),
        .rst_n (RESET_n),
        .din   (bus.INDEX_IN),
        .pulse (index_e)
    );

    state_t           state, state_n;
    logic [CNT_W-1:0] mcnt, mcnt_n, mcnt_inc, cfg_mc, mc_eff;
    logic [GAP_W-1:0] gap, gap_n, gap_inc, cfg_gap;
    logic [7:0]       icnt, icnt_n, icnt_inc, cfg_il;
    logic [LEN_W-1:0] lcnt, lcnt_n, lcnt_inc, cfg_len;
    logic             cfg_load, sync_found, complete;

    // Saturating increments
    assign mcnt_inc = (&mcnt) ? mcnt : mcnt + 1'b1;
    assign gap_inc  = (&gap)  ? gap  : gap  + 1'b1;
    assign icnt_inc = (&icnt) ? icnt : icnt + 1'b1;
    assign lcnt_inc = (&lcnt) ? lcnt : lcnt + 1'b1;

    // A required count of 0 behaves as 1
    assign mc_eff = (cfg_mc == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : cfg_mc;

    always_ff @(posedge CLK_PLL32MHZ or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= ST_IDLE;
            mcnt    <= '0;
            gap     <= '0;
            icnt    <= '0;
            lcnt    <= '0;
            cfg_mc  <= '0;
            cfg_gap <= '0;
            cfg_il  <= '0;
            cfg_len <= '0;
        end else begin
            state <= state_n;
            mcnt  <= mcnt_n;
            gap   <= gap_n;
            icnt  <= icnt_n;
            lcnt  <= lcnt_n;
            if (cfg_load) begin
                cfg_mc  <= bus.MATCH_COUNT;
                cfg_gap <= bus.GAP_LIMIT;
                cfg_il  <= bus.INDEX_LIMIT;
                cfg_len <= bus.ACQ_LEN;
            end
        end
    end

    always_comb begin
        state_n    = state;
        mcnt_n     = mcnt;
        gap_n      = gap;
        icnt_n     = icnt;
        lcnt_n     = lcnt;
        cfg_load   = 1'b0;
        sync_found = 1'b0;
        complete   = 1'b0;

        if (bus.ABORT) begin
            state_n = ST_IDLE;
            mcnt_n  = '0;
            gap_n   = '0;
            icnt_n  = '0;
            lcnt_n  = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (bus.START) begin
                        cfg_load = 1'b1;
                        mcnt_n   = '0;
                        gap_n    = '0;
                        icnt_n   = '0;
                        lcnt_n   = '0;
                        state_n  = bus.WAIT_INDEX ? ST_WAIT_IDX : ST_SEARCH;
                    end
                end
                ST_WAIT_IDX: begin
                    if (index_e) begin
                        state_n = ST_SEARCH;
                        icnt_n  = '0;
                        mcnt_n  = '0;
                        gap_n   = '0;
                    end
                end
                ST_SEARCH: begin
                    if (match_e) begin
                        gap_n = '0;
                        if (mcnt_inc >= mc_eff) begin
                            complete   = 1'b1;
                            sync_found = 1'b1;
                            state_n    = ST_ACQUIRE;
                            mcnt_n     = '0;
                            lcnt_n     = '0;
                        end else begin
                            mcnt_n = mcnt_inc;
                        end
                    end else if (mcnt != '0) begin
                        // Gap only runs while a partial sequence is pending
                        if (gap_inc >= cfg_gap) begin
                            mcnt_n = '0;
                            gap_n  = '0;
                        end else begin
                            gap_n = gap_inc;
                        end
                    end
                    // A completing match on the same clock suppresses timeout
                    if (index_e && !complete) begin
                        icnt_n = icnt_inc;
                        if (cfg_il != '0 && icnt_inc >= cfg_il)
                            state_n = ST_TIMEOUT;
                    end
                end
                ST_ACQUIRE: begin
                    lcnt_n = lcnt_inc;
                    if (cfg_len != '0 && lcnt_inc >= cfg_len)
                        state_n = ST_DONE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Status decodes straight from state so async reset clears them at once
    assign bus.ACQ_RUN    = (state == ST_ACQUIRE);
    assign bus.SYNC_FOUND = sync_found;
    assign bus.BUSY       = (state == ST_WAIT_IDX) || (state == ST_SEARCH) ||
                            (state == ST_ACQUIRE);
    assign bus.DONE       = (state == ST_DONE);
    assign bus.TIMED_OUT  = (state == ST_TIMEOUT);
endmodule
